// File: rtl/data_mem_ctrl.sv
// Data-memory controller: turns pipeline loads/stores into word-wide backing-memory
// transactions with lane steering, load extension, alignment faults and an ack timeout.
module data_mem_ctrl #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  mem_stall,
    output logic                  misaligned,
    output logic                  bus_error,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DM_ADDRESS-3:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef struct packed {
        logic [DM_ADDRESS-1:0] addr;
        logic [DATA_W-1:0]     wdata;
        logic [2:0]            func3;
        logic                  we;
    } cmd_t;

    state_e            state_q;
    cmd_t              cmd_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              misaligned_q;
    logic              bus_error_q;

    logic              access;
    logic              aligned;
    logic              start;

    // Reserved size codes (011/110/111) are reported as alignment faults.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        aligned = 1'b0;
        case (func3)
            3'b000, 3'b100: aligned = 1'b1;
            3'b001, 3'b101: aligned = ~addr[0];
            3'b010:         aligned = (addr[1:0] == 2'b00);
            default:        aligned = 1'b0;
        endcase
    end

    assign access    = MemRead | MemWrite;
    assign start     = (state_q == IDLE) && access && aligned;
    assign mem_stall = ~reset & (start | (state_q == BUSY));

    function automatic logic [DATA_W-1:0] load_extend(
        input logic [2:0]        f3,
        input logic [1:0]        off,
        input logic [DATA_W-1:0] word
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = word[{off, 3'b000} +: 8];
        half_v = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  load_extend = {{(DATA_W - 8){byte_v[7]}}, byte_v};
            3'b100:  load_extend = {{(DATA_W - 8){1'b0}}, byte_v};
            3'b001:  load_extend = {{(DATA_W - 16){half_v[15]}}, half_v};
            3'b101:  load_extend = {{(DATA_W - 16){1'b0}}, half_v};
            default: load_extend = word;
        endcase
    endfunction

    // The bus is decoded purely from the latched command, so the pipeline may
    // change addr/wr_data/func3 freely while the access is outstanding.
    always_comb begin
        mem_req   = (state_q == BUSY);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'b0000;
        mem_wdata = '0;
        if (state_q == BUSY) begin
            mem_we   = cmd_q.we;
            mem_addr = cmd_q.addr[DM_ADDRESS-1:2];
            mem_be   = 4'b1111;
            if (cmd_q.we) begin
                case (cmd_q.func3[1:0])
                    2'b00: begin
                        mem_be    = 4'b0001 << cmd_q.addr[1:0];
                        mem_wdata = {(DATA_W / 8){cmd_q.wdata[7:0]}};
                    end
                    2'b01: begin
                        mem_be    = cmd_q.addr[1] ? 4'b1100 : 4'b0011;
                        mem_wdata = {(DATA_W / 16){cmd_q.wdata[15:0]}};
                    end
                    default: mem_wdata = cmd_q.wdata;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            wait_cnt_q   <= '0;
            rd_data_q    <= '0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            cmd_q.addr  <= addr;
                            cmd_q.wdata <= wr_data;
                            cmd_q.func3 <= func3;
                            cmd_q.we    <= MemWrite;
                            wait_cnt_q  <= '0;
                            state_q     <= BUSY;
                        end else begin
                            misaligned_q <= 1'b1;
                            rd_data_q    <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        rd_data_q <= cmd_q.we ? '0
                                   : load_extend(cmd_q.func3, cmd_q.addr[1:0], mem_rdata);
                        state_q   <= DONE;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        bus_error_q <= 1'b1;
                        rd_data_q   <= '0;
                        state_q     <= DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                // The request is still present here; it belongs to the finished access.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_data    = rd_data_q;
    assign misaligned = misaligned_q;
    assign bus_error  = bus_error_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: per-cycle comparison against a transaction-level
// model, directed literal cases, then randomized loads/stores/faults/timeouts.
module tb_data_mem_ctrl;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          MemRead;
    logic          MemWrite;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [2:0]    func3;
    logic [DW-1:0] rd_data;
    logic          mem_stall;
    logic          misaligned;
    logic          bus_error;
    logic          mem_req;
    logic          mem_we;
    logic [AW-3:0] mem_addr;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .DM_ADDRESS(AW),
        .DATA_W    (DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .addr      (addr),
        .wr_data   (wr_data),
        .func3     (func3),
        .rd_data   (rd_data),
        .mem_stall (mem_stall),
        .misaligned(misaligned),
        .bus_error (bus_error),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle.
    logic          e_stall, e_req, e_mis, e_berr, e_we;
    logic [DW-1:0] e_rd, e_wdata;
    logic [AW-3:0] e_addr;
    logic [3:0]    e_be;
    bit            e_zero_bus;

    // Model state.
    logic [DW-1:0] m_rd;
    bit            mis_pending;

    // Observation counters (monotonic) and last bus values seen while mem_req=1.
    int            n_stall, n_req, n_mis, n_berr;
    int            b_stall, b_req, b_mis, b_berr;
    logic [AW-3:0] o_addr;
    logic [3:0]    o_be;
    logic [DW-1:0] o_wdata;
    logic          o_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic bit is_aligned(input logic [2:0] f3, input int a);
        case (f3)
            3'b000, 3'b100: return 1'b1;
            3'b001, 3'b101: return (a % 2) == 0;
            3'b010:         return (a % 4) == 0;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] f3, input int a, input logic [31:0] word);
        int          off;
        logic [31:0] b;
        logic [31:0] h;
        off = a % 4;
        b   = (word >> (8 * off)) & 32'hFF;
        h   = (word >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input int a);
        case (f3)
            3'b000:  return 4'(1 << (a % 4));
            3'b001:  return ((a % 4) < 2) ? 4'b0011 : 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            3'b000:  return (wd & 32'hFF) * 32'h0101_0101;
            3'b001:  return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    // ---------------- per-cycle compare ----------------
    task automatic compare_cycle();
        check("mem_stall", 32'(mem_stall), 32'(e_stall));
        check("mem_req", 32'(mem_req), 32'(e_req));
        check("misaligned", 32'(misaligned), 32'(e_mis));
        check("bus_error", 32'(bus_error), 32'(e_berr));
        check("rd_data", rd_data, e_rd);
        if (e_zero_bus) begin
            check("reset_mem_we", 32'(mem_we), 32'h0);
            check("reset_mem_addr", 32'(mem_addr), 32'h0);
            check("reset_mem_be", 32'(mem_be), 32'h0);
            check("reset_mem_wdata", mem_wdata, 32'h0);
        end else if (e_req) begin
            check("mem_we", 32'(mem_we), 32'(e_we));
            check("mem_addr", 32'(mem_addr), 32'(e_addr));
            check("mem_be", 32'(mem_be), 32'(e_be));
            if (e_we) check("mem_wdata", mem_wdata, e_wdata);
        end
        if (mem_stall)  n_stall++;
        if (misaligned) n_mis++;
        if (bus_error)  n_berr++;
        if (mem_req) begin
            n_req++;
            o_addr  = mem_addr;
            o_be    = mem_be;
            o_wdata = mem_wdata;
            o_we    = mem_we;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic stall, input logic req, input logic berr);
        e_stall    = stall;
        e_req      = req;
        e_berr     = berr;
        e_zero_bus = 1'b0;
        e_mis      = mis_pending;
        if (mis_pending) m_rd = '0;
        mis_pending = 1'b0;
        e_rd        = m_rd;
    endtask

    task automatic snap();
        b_stall = n_stall;
        b_req   = n_req;
        b_mis   = n_mis;
        b_berr  = n_berr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            addr      = AW'($urandom);
            func3     = 3'($urandom);
            mem_ack   = 1'($urandom);
            mem_rdata = $urandom;
            set_exp(1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    // One pipeline access; ack_at = BUSY cycle carrying mem_ack (> TO means never).
    task automatic do_access(input logic rd_en, input logic wr_en, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input logic [2:0] f3, input int ack_at,
                             input logic [DW-1:0] ack_word, input bit late_ack);
        bit            timed_out;
        logic [DW-1:0] word;
        logic [DW-1:0] result;
        snap();
        MemRead   = rd_en;
        MemWrite  = wr_en;
        addr      = a;
        wr_data   = wd;
        func3     = f3;
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
        if (!is_aligned(f3, int'(a))) begin
            set_exp(1'b0, 1'b0, 1'b0);
            tick();
            mis_pending = 1'b1;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            return;
        end
        set_exp(1'b1, 1'b0, 1'b0);
        tick();
        e_we      = wr_en;
        e_addr    = (AW - 2)'(int'(a) / 4);
        e_be      = wr_en ? store_be(f3, int'(a)) : 4'b1111;
        e_wdata   = store_data(f3, wd);
        timed_out = 1'b1;
        word      = '0;
        for (int k = 1; k <= TO; k++) begin
            addr      = AW'($urandom);
            wr_data   = $urandom;
            func3     = 3'($urandom);
            mem_ack   = (k == ack_at);
            mem_rdata = (k == ack_at) ? ack_word : $urandom;
            set_exp(1'b1, 1'b1, 1'b0);
            tick();
            if (k == ack_at) begin
                timed_out = 1'b0;
                word      = ack_word;
                break;
            end
        end
        result    = (timed_out || wr_en) ? '0 : load_value(f3, int'(a), word);
        addr      = a;
        wr_data   = wd;
        func3     = f3;
        mem_ack   = late_ack;
        mem_rdata = $urandom;
        m_rd      = result;
        set_exp(1'b0, 1'b0, timed_out);
        tick();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        mem_ack  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic       rd_en, wr_en;
        logic [2:0] f3;
        int         sel, ack_at;

        n_stall = 0; n_req = 0; n_mis = 0; n_berr = 0;
        mis_pending = 1'b0;
        m_rd      = '0;
        reset     = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        addr      = '0;
        wr_data   = '0;
        func3     = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            set_exp(1'b0, 1'b0, 1'b0);
            e_zero_bus = 1'b1;
            tick();
        end
        reset = 1'b0;
        idle(2);

        // LW 0x010, ack on first BUSY cycle
        do_access(1'b1, 1'b0, 9'h010, 32'h0, 3'b010, 1, 32'hDEAD_BEEF, 1'b0);
        check("lw_rd_data", rd_data, 32'hDEAD_BEEF);
        check("lw_mem_addr", 32'(o_addr), 32'h04);
        check("lw_mem_be", 32'(o_be), 32'hF);
        check("lw_mem_we", 32'(o_we), 32'h0);
        check("lw_stall_cycles", 32'(n_stall - b_stall), 32'd2);
        check("lw_busy_cycles", 32'(n_req - b_req), 32'd1);

        // SH 0x006
        do_access(1'b0, 1'b1, 9'h006, 32'h0000_ABCD, 3'b001, 2, 32'h5555_5555, 1'b0);
        check("sh_mem_we", 32'(o_we), 32'h1);
        check("sh_mem_be", 32'(o_be), 32'hC);
        check("sh_mem_wdata", o_wdata, 32'hABCD_ABCD);
        check("sh_rd_data", rd_data, 32'h0);

        // LB / LBU 0x013
        do_access(1'b1, 1'b0, 9'h013, 32'h0, 3'b000, 2, 32'h8011_2233, 1'b0);
        check("lb_rd_data", rd_data, 32'hFFFF_FF80);
        do_access(1'b1, 1'b0, 9'h013, 32'h0, 3'b100, 1, 32'h8011_2233, 1'b1);
        check("lbu_rd_data", rd_data, 32'h0000_0080);

        // Misaligned LW 0x002
        do_access(1'b1, 1'b0, 9'h002, 32'h0, 3'b010, 1, 32'h0, 1'b0);
        idle(2);
        check("mis_pulse_cycles", 32'(n_mis - b_mis), 32'd1);
        check("mis_req_cycles", 32'(n_req - b_req), 32'd0);
        check("mis_stall_cycles", 32'(n_stall - b_stall), 32'd0);
        check("mis_rd_data", rd_data, 32'h0);

        // LH timeout with late ack
        do_access(1'b1, 1'b0, 9'h020, 32'h0, 3'b010, 3, 32'h1234_5678, 1'b0);
        check("pre_timeout_rd", rd_data, 32'h1234_5678);
        do_access(1'b1, 1'b0, 9'h00A, 32'h0, 3'b001, TO + 1, 32'h0, 1'b1);
        idle(2);
        check("to_busy_cycles", 32'(n_req - b_req), 32'd15);
        check("to_stall_cycles", 32'(n_stall - b_stall), 32'd16);
        check("to_bus_error_cycles", 32'(n_berr - b_berr), 32'd1);
        check("to_rd_data", rd_data, 32'h0);

        // Reset on third BUSY cycle of an LH, then a stray ack
        do_access(1'b1, 1'b0, 9'h031, 32'h0, 3'b100, 1, 32'h0000_7700, 1'b0);
        snap();
        MemRead = 1'b1; MemWrite = 1'b0; addr = 9'h024; func3 = 3'b001; mem_ack = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0);
        tick();
        e_we = 1'b0; e_addr = 7'h09; e_be = 4'hF;
        for (int i = 0; i < 2; i++) begin
            set_exp(1'b1, 1'b1, 1'b0);
            tick();
        end
        reset = 1'b1;
        set_exp(1'b0, 1'b1, 1'b0);
        tick();
        reset = 1'b0; MemRead = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        m_rd = '0;
        set_exp(1'b0, 1'b0, 1'b0);
        e_zero_bus = 1'b1;
        tick();
        mem_ack = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0);
        e_zero_bus = 1'b1;
        tick();
        check("rst_busy_cycles", 32'(n_req - b_req), 32'd3);
        check("rst_rd_data", rd_data, 32'h0);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            sel   = int'($urandom_range(0, 2));
            rd_en = (sel != 1);
            wr_en = (sel != 0);
            f3    = 3'($urandom_range(0, 7));
            if (wr_en && (f3 == 3'b100 || f3 == 3'b101)) f3 = f3 - 3'd4;
            ack_at = int'($urandom_range(1, 6));
            if ($urandom_range(0, 7) == 0)  ack_at = TO + 1;
            if ($urandom_range(0, 15) == 0) ack_at = TO;
            do_access(rd_en, wr_en, AW'($urandom), $urandom, f3, ack_at, $urandom, 1'($urandom));
            idle(int'($urandom_range(0, 2)));
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameters: DM_ADDRESS, default 9, byte address width; DATA_W, default 32, data width; TIMEOUT, default 15, maximum wait cycles for mem_ack.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- MemRead  in  1  load request from the EX/MEM register.
- MemWrite  in  1  store request from the EX/MEM register.
- addr  in  DM_ADDRESS  byte address (ALU result).
- wr_data  in  DATA_W  store data (forwarded rs2).
- func3  in  3  access size and sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- rd_data  out  DATA_W  extended load result to MEM/WB.
- mem_stall  out  1  pipeline hold request.
- misaligned  out  1  one-cycle alignment-fault pulse.
- bus_error  out  1  one-cycle timeout pulse.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  backing-memory write enable.
- mem_addr  out  DM_ADDRESS-2  word address.
- mem_be  out  4  byte enables.
- mem_wdata  out  DATA_W  lane-aligned write data.
- mem_rdata  in  DATA_W  backing-memory read word.
- mem_ack  in  1  backing-memory completion, valid when mem_req=1.

Function
REQ-003 SHALL use a three-state FSM: IDLE, BUSY, DONE.
REQ-004 In IDLE, an access (MemRead|MemWrite) that is aligned SHALL latch addr, wr_data, func3 and write-flag, assert mem_stall combinationally the same cycle, and move to BUSY.
REQ-005 When MemRead and MemWrite are both 1, the access SHALL be treated as a store.
REQ-006 Alignment rules: halfword needs addr[0]=0; word needs addr[1:0]=00; byte is always aligned; func3 011/110/111 SHALL be treated as misaligned.
REQ-007 A misaligned access in IDLE SHALL pulse misaligned for one cycle, issue no mem_req, keep mem_stall=0, drive rd_data=0, and stay in IDLE.
REQ-008 In BUSY, mem_req SHALL be 1, mem_stall SHALL be 1, and mem_addr/mem_be/mem_wdata/mem_we SHALL be driven from the latched command only.
REQ-009 Store lanes: SB SHALL replicate byte to all lanes with be=0001<<addr[1:0]; SH SHALL replicate halfword with be=0011 or 1100 per addr[1]; SW SHALL use be=1111.
REQ-010 Loads SHALL use be=1111 and mem_we=0.
REQ-011 On mem_ack in BUSY, read data SHALL be captured and extended per latched func3 and offset, and the FSM SHALL move to DONE.
REQ-012 Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word; stores yield rd_data=0.
REQ-013 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack. On reaching TIMEOUT, the FSM SHALL go to DONE with bus_error pulsed that cycle and the result forced to 0.
REQ-014 In DONE, mem_stall SHALL be 0, mem_req SHALL be 0, and rd_data SHALL hold the result. The next state SHALL be IDLE unconditionally; the still-present request SHALL NOT retrigger.
REQ-015 rd_data SHALL hold its last value in IDLE until the next completed load or fault.
REQ-016 A mem_ack arriving while not in BUSY SHALL be ignored.
REQ-017 Access latency SHALL be 1 cycle (IDLE) + N cycles (BUSY, ack on the Nth) + 1 cycle (DONE). The minimum stall is 2 cycles.

Reset
REQ-018 On reset, the FSM SHALL go to IDLE and all of the following SHALL be 0: counter, latched command, rd_data, misaligned, bus_error, mem_req, mem_we, mem_be, mem_addr, mem_wdata.
REQ-019 Reset during BUSY SHALL drop mem_req at the same edge and discard any in-flight ack.
REQ-020 mem_stall SHALL be 0 while reset is high.

Verification
REQ-021 LW at addr 0x010, mem_rdata=0xDEADBEEF, ack after 1 BUSY cycle -> mem_addr=0x04, be=1111, stall 2 cycles, rd_data=0xDEADBEEF in DONE.
REQ-022 LB at addr 0x013, mem_rdata=0x80112233 -> rd_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-023 SH at addr 0x006, wr_data=0x0000ABCD -> mem_we=1, be=1100, mem_wdata=0xABCDABCD, rd_data=0.
REQ-024 LW at addr 0x002 -> misaligned pulse 1 cycle, mem_req never asserted, mem_stall=0.
REQ-025 LH with mem_ack held 0 -> 15 BUSY cycles, then DONE with bus_error=1 and rd_data=0; a late ack afterwards is ignored.
REQ-026 Reset asserted on the 3rd BUSY cycle -> next cycle IDLE, mem_req=0, all outputs 0; an ack on the following cycle causes no state change.
